// File: rtl/sd_pkg.sv
// Purpose: shared constants, state and error-code types for the SD SPI block receiver.
// Latency: none (types and constants only).
// Backpressure: none.
package sd_pkg;

   localparam logic [7:0] SD_START_TOKEN = 8'hFE;
   localparam logic [7:0] SD_FILL_BYTE   = 8'hFF;

   typedef enum logic [1:0] {
      SD_ERR_NONE       = 2'b00,
      SD_ERR_TIMEOUT    = 2'b01,
      SD_ERR_DATA_TOKEN = 2'b10,
      SD_ERR_CRC        = 2'b11
   } sd_err_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_TOKEN_HUNT = 3'd1,
      ST_DATA       = 3'd2,
      ST_CRC        = 3'd3,
      ST_DONE       = 3'd4,
      ST_ERROR      = 3'd5
   } sd_state_e;

   // A data-error token has its top three bits clear and is not all-zero.
   function automatic logic is_data_err_token(input logic [7:0] b);
      return (b[7:5] == 3'b000) && (b != 8'h00);
   endfunction

endpackage

// File: rtl/sd_crc16.sv
// Purpose: serial CRC16-CCITT (poly 0x1021, init 0x0000), one bit per enabled cycle, MSB first.
// Latency: crc reflects a bit the cycle after bit_en; clear wins over bit_en.
// Backpressure: none; the caller decides when bits are valid.
module sd_crc16 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        bit_en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   // Next CRC value: shift left, fold in the polynomial when the feedback bit is set.
   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[15] ^ bit_in;
      if (clear) begin
         crc_d = 16'h0000;
      end else if (bit_en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
   end

   // CRC register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) crc_q <= 16'h0000;
      else          crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_block_rx.sv
// Purpose: SPI-mode SD single-block read data phase: token hunt, 512-byte payload as 32-bit words, CRC16.
// Latency: 16*CLK_DIV clk per byte; a word is presented the cycle after its 4th byte completes.
// Backpressure: word_ready low holds word_valid and parks sclk low before the next byte. Macro: SD_BLOCK_RX_CRC16_EN.
module sd_block_rx
   import sd_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int TOKEN_TIMEOUT = 4096,
   parameter int BLOCK_BYTES   = 512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [6:0]  word_index
);

   localparam int              DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int              TW        = $clog2(TOKEN_TIMEOUT + 1);
   localparam logic [DW-1:0]   DIV_TOP   = DW'(CLK_DIV - 1);
   localparam logic [TW-1:0]   HUNT_TOP  = TW'(TOKEN_TIMEOUT - 1);
   localparam logic [6:0]      LAST_WORD = 7'(BLOCK_BYTES / 4 - 1);

   // Byte engine state
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    edge_q, edge_d;
   logic          sclk_q, sclk_d;
   logic [7:0]    shift_q, shift_d;
   logic          run, tick, rise, byte_done;

   // Control state
   sd_state_e     state_q, state_d;
   sd_err_e       err_q, err_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic          crcb_q, crcb_d;
   logic [6:0]    widx_q, widx_d;
   logic          wvld_q, wvld_d;
   logic [31:0]   word_q, word_d;

   // Bytes only run at byte boundaries are paused: a pending word parks the bus with sclk low.
   assign run       = (state_q == ST_TOKEN_HUNT) || (state_q == ST_CRC) ||
                      ((state_q == ST_DATA) && !wvld_q);
   assign tick      = run && (div_q == DIV_TOP);
   assign rise      = tick && !sclk_q;
   assign byte_done = tick && (edge_q == 4'd15);

`ifdef SD_BLOCK_RX_CRC16_EN
   logic [15:0] crc_rx_q, crc_rx_d, crc_calc;

   sd_crc16 u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   ((state_q == ST_IDLE) && start),
      .bit_en  (rise && (state_q == ST_DATA)),
      .bit_in  (miso),
      .crc     (crc_calc)
   );
`endif

   // Half-period divider, sclk toggle and MSB-first sampling on each rising edge.
   always_comb begin
      div_d   = div_q;
      edge_d  = edge_q;
      sclk_d  = sclk_q;
      shift_d = shift_q;
      if (run) begin
         if (tick) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            edge_d = edge_q + 4'd1;
            if (rise) shift_d = {shift_q[6:0], miso};
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   // Byte engine registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q   <= '0;
         edge_q  <= 4'd0;
         sclk_q  <= 1'b0;
         shift_q <= 8'h00;
      end else begin
         div_q   <= div_d;
         edge_q  <= edge_d;
         sclk_q  <= sclk_d;
         shift_q <= shift_d;
      end
   end

   // Phase sequencing, word packing, handshake and error classification.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      crcb_d  = crcb_q;
      widx_d  = widx_q;
      wvld_d  = wvld_q;
      word_d  = word_q;
`ifdef SD_BLOCK_RX_CRC16_EN
      crc_rx_d = crc_rx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_TOKEN_HUNT;
               err_d   = SD_ERR_NONE;
               cnt_d   = '0;
               bcnt_d  = 2'd0;
               crcb_d  = 1'b0;
               widx_d  = 7'd0;
            end
         end
         ST_TOKEN_HUNT: begin
            if (byte_done) begin
               if (shift_q == SD_START_TOKEN) begin
                  state_d = ST_DATA;
               end else if (is_data_err_token(shift_q)) begin
                  state_d = ST_ERROR;
                  err_d   = SD_ERR_DATA_TOKEN;
               end else if (cnt_q == HUNT_TOP) begin
                  state_d = ST_ERROR;
                  err_d   = SD_ERR_TIMEOUT;
               end else begin
                  cnt_d = cnt_q + TW'(1);
               end
            end
         end
         ST_DATA: begin
            if (byte_done) begin
               word_d = {word_q[23:0], shift_q};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) wvld_d = 1'b1;
            end
            if (wvld_q && word_ready) begin
               wvld_d = 1'b0;
               widx_d = widx_q + 7'd1;
               if (widx_q == LAST_WORD) state_d = ST_CRC;
            end
         end
         ST_CRC: begin
            if (byte_done) begin
               crcb_d = 1'b1;
`ifdef SD_BLOCK_RX_CRC16_EN
               crc_rx_d = {crc_rx_q[7:0], shift_q};
               if (crcb_q) begin
                  if (crc_rx_d != crc_calc) begin
                     state_d = ST_ERROR;
                     err_d   = SD_ERR_CRC;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
`else
               if (crcb_q) state_d = ST_DONE;
`endif
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Control registers; reset aborts any transfer silently.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         err_q   <= SD_ERR_NONE;
         cnt_q   <= '0;
         bcnt_q  <= 2'd0;
         crcb_q  <= 1'b0;
         widx_q  <= 7'd0;
         wvld_q  <= 1'b0;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         crcb_q  <= crcb_d;
         widx_q  <= widx_d;
         wvld_q  <= wvld_d;
         word_q  <= word_d;
      end
   end

`ifdef SD_BLOCK_RX_CRC16_EN
   // Received CRC bytes, MSB byte first.
   always_ff @(posedge clk) begin
      if (!reset_n) crc_rx_q <= 16'h0000;
      else          crc_rx_q <= crc_rx_d;
   end
`endif

   assign busy       = (state_q == ST_TOKEN_HUNT) || (state_q == ST_DATA) || (state_q == ST_CRC);
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERROR);
   assign err_code   = err_q;
   assign sclk       = sclk_q;
   assign mosi       = SD_FILL_BYTE[7];
   assign word_data  = word_q;
   assign word_valid = wvld_q;
   assign word_index = widx_q;

endmodule

// File: tb/tb_sd_block_rx.sv
// Bench for sd_block_rx: card model on miso, scoreboard of expected words, directed scenarios.
// Expected words are pushed when a block is loaded; the monitor pops them on each handshake.
// Covers reset, full block, data-error token, timeout, ready stalls, mid-transfer reset, CRC corruption.
module tb_sd_block_rx;

   localparam int CLK_DIV       = 1;
   localparam int TOKEN_TIMEOUT = 16;
   localparam int BLOCK_BYTES   = 512;
   localparam int NW            = BLOCK_BYTES / 4;
   localparam int BYTE_CLK      = 16 * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        miso = 1'b1;
   logic        word_ready = 1'b0;
   logic        busy, done, error, sclk, mosi, word_valid;
   logic [1:0]  err_code;
   logic [31:0] word_data;
   logic [6:0]  word_index;

   sd_block_rx #(
      .CLK_DIV       (CLK_DIV),
      .TOKEN_TIMEOUT (TOKEN_TIMEOUT),
      .BLOCK_BYTES   (BLOCK_BYTES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .sclk       (sclk),
      .mosi       (mosi),
      .miso       (miso),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_index (word_index)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- card model: shifts a byte stream out MSB first, changing after sclk falls
   logic [7:0] stream[$];
   int         byte_i = 0;
   int         bit_i  = 0;

   task automatic drive_miso();
      if (byte_i < stream.size()) miso = stream[byte_i][7 - bit_i];
      else                        miso = 1'b1;
   endtask

   task automatic rewind();
      byte_i = 0;
      bit_i  = 0;
      drive_miso();
   endtask

   always @(negedge sclk) begin
      bit_i++;
      if (bit_i == 8) begin
         bit_i = 0;
         byte_i++;
      end
      drive_miso();
   end

   // ---------------- scoreboard
   typedef struct packed {
      logic [31:0] dat;
      logic [6:0]  idx;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          words_seen, done_cnt, err_cnt, vld_cnt;
   logic [31:0] first_word, last_word;
   logic        sclk_in_stall;

   function automatic logic [7:0] pat_byte(input int pat, input int i);
      case (pat)
         0:       return 8'(i);
         1:       return 8'(i * 7 + 3);
         default: return 8'(255 - i);
      endcase
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int k = 7; k >= 0; k--) begin
         fb = r[15] ^ b[k];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   task automatic load_block(input int pat, input int nff, input bit flip);
      logic [15:0] crc;
      logic [7:0]  b;
      logic [31:0] w;
      exp_t        e;
      stream.delete();
      exp_q.delete();
      crc = 16'h0000;
      w   = 32'h0;
      for (int i = 0; i < nff; i++) stream.push_back(8'hFF);
      stream.push_back(8'hFE);
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         b = pat_byte(pat, i);
         stream.push_back(b);
         crc = crc16_byte(crc, b);
         w   = {w[23:0], b};
         if (i % 4 == 3) begin
            e.dat = w;
            e.idx = 7'(i / 4);
            exp_q.push_back(e);
         end
      end
      if (flip) crc = crc ^ 16'h0100;
      stream.push_back(crc[15:8]);
      stream.push_back(crc[7:0]);
      rewind();
   endtask

   task automatic clear_stats();
      words_seen    = 0;
      done_cnt      = 0;
      err_cnt       = 0;
      vld_cnt       = 0;
      first_word    = 32'hDEADBEEF;
      last_word     = 32'hDEADBEEF;
      sclk_in_stall = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (word_valid && sclk) sclk_in_stall = 1'b1;
         if (word_valid) vld_cnt++;
         if (done) done_cnt++;
         if (error) err_cnt++;
         if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got index %0d data 0x%0h, expected no word", word_index, word_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("word_data", word_data, mon_e.dat);
               check("word_index", 32'(word_index), 32'(mon_e.idx));
               check("sclk_low_while_valid", 32'(sclk_in_stall), 32'd0);
            end
            if (word_index == 7'd0)   first_word = word_data;
            if (word_index == 7'd127) last_word  = word_data;
            words_seen++;
            sclk_in_stall = 1'b0;
         end
      end
   end

   // ---------------- ready driver for the stall scenario: ready low 0..20 cycles per word
   bit stall_mode = 1'b0;

   initial begin : rdy_drv
      int n;
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode && word_valid && !word_ready) begin
            n = $urandom_range(0, 20);
            repeat (n) @(posedge clk);
            #1 word_ready = 1'b1;
            @(posedge clk);
            #1 word_ready = 1'b0;
         end
      end
   end

   // ---------------- helpers
   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Returns the number of negedges sampled until done or error; the pulse lands
   // at cyc = (clk cycles from the start-accepting edge) + 1.
   task automatic wait_end(input int budget, output int cyc);
      cyc = 0;
      while (!(done || error) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (!(done || error)) begin
         checks++;
         errors++;
         $display("FAIL end_wait: got no done/error after %0d cycles, expected a pulse", cyc);
      end
   endtask

   initial begin : watchdog
      #4000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios
   initial begin : main
      int cyc;
      int dc, ec;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_error",      32'(error),      32'd0);
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_sclk",       32'(sclk),       32'd0);
      check("rst_mosi",       32'(mosi),       32'd1);
      check("rst_err_code",   32'(err_code),   32'd0);
      check("rst_word_data",  word_data,       32'h0);
      check("rst_word_index", 32'(word_index), 32'd0);
      reset_n = 1'b1;

      // T1: 3x FF, token, 00..FF twice, CRC, ready always high
      word_ready = 1'b1;
      load_block(0, 3, 1'b0);
      clear_stats();
      pulse_start();
      check("t1_busy_after_start", 32'(busy), 32'd1);
      wait_end(20000, cyc);
      check("t1_done", 32'(done), 32'd1);
      check("t1_error", 32'(error), 32'd0);
      // start during the done pulse must be ignored
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("t1_done_single", 32'(done), 32'd0);
      check("t1_busy_after_done", 32'(busy), 32'd0);
      check("t1_done_count", 32'(done_cnt), 32'd1);
      check("t1_words", 32'(words_seen), 32'(NW));
      check("t1_word0", first_word, 32'h00010203);
      check("t1_word127", last_word, 32'hFCFDFEFF);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
      check("t1_err_code", 32'(err_code), 32'd0);

      // T2: data-error token 0x09 after 2x FF
      stream.delete();
      exp_q.delete();
      stream.push_back(8'hFF);
      stream.push_back(8'hFF);
      stream.push_back(8'h09);
      rewind();
      clear_stats();
      pulse_start();
      wait_end(2000, cyc);
      check("t2_error", 32'(error), 32'd1);
      check("t2_latency", 32'(cyc), 32'(3 * BYTE_CLK + 1));
      check("t2_err_code", 32'(err_code), 32'd2);
      @(negedge clk);
      check("t2_busy_after", 32'(busy), 32'd0);
      check("t2_err_count", 32'(err_cnt), 32'd1);
      check("t2_no_valid", 32'(vld_cnt), 32'd0);

      // T3: miso idle high -> timeout after exactly TOKEN_TIMEOUT bytes
      stream.delete();
      rewind();
      clear_stats();
      pulse_start();
      check("t3_err_code_cleared", 32'(err_code), 32'd0);
      wait_end(2000, cyc);
      check("t3_error", 32'(error), 32'd1);
      check("t3_latency", 32'(cyc), 32'(TOKEN_TIMEOUT * BYTE_CLK + 1));
      check("t3_err_code", 32'(err_code), 32'd1);
      @(negedge clk);
      check("t3_err_code_held", 32'(err_code), 32'd1);
      check("t3_no_valid", 32'(vld_cnt), 32'd0);

      // T4: random ready stalls
      word_ready = 1'b0;
      stall_mode = 1'b1;
      load_block(1, 5, 1'b0);
      clear_stats();
      pulse_start();
      wait_end(40000, cyc);
      check("t4_done", 32'(done), 32'd1);
      stall_mode = 1'b0;
      @(negedge clk);
      word_ready = 1'b1;
      check("t4_words", 32'(words_seen), 32'(NW));
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
      check("t4_done_count", 32'(done_cnt), 32'd1);

      // T5: reset in the middle of the data phase, then a clean transfer
      load_block(2, 1, 1'b0);
      clear_stats();
      pulse_start();
      cyc = 0;
      while (words_seen < 40 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_reached_word40", 32'(words_seen >= 40), 32'd1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("t5_rst_sclk", 32'(sclk), 32'd0);
      check("t5_rst_mosi", 32'(mosi), 32'd1);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_valid", 32'(word_valid), 32'd0);
      check("t5_rst_index", 32'(word_index), 32'd0);
      dc = done_cnt;
      ec = err_cnt;
      reset_n = 1'b1;
      exp_q.delete();
      repeat (20) @(negedge clk);
      check("t5_no_pulse", 32'(done_cnt + err_cnt), 32'(dc + ec));
      load_block(0, 2, 1'b0);
      clear_stats();
      pulse_start();
      wait_end(20000, cyc);
      check("t5_done", 32'(done), 32'd1);
      @(negedge clk);
      check("t5_words", 32'(words_seen), 32'(NW));
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // T6: corrupted CRC (one bit flipped)
      load_block(1, 3, 1'b1);
      clear_stats();
      pulse_start();
      wait_end(20000, cyc);
`ifdef SD_BLOCK_RX_CRC16_EN
      check("t6_error", 32'(error), 32'd1);
      check("t6_err_code", 32'(err_code), 32'd3);
`else
      check("t6_done", 32'(done), 32'd1);
      check("t6_err_code", 32'(err_code), 32'd0);
`endif
      @(negedge clk);
      check("t6_words", 32'(words_seen), 32'(NW));
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
